// File: rtl/mmio_led_pwm_pkg.sv
// mmio_led_pwm shared definitions
// Register word offsets and the byte-lane merge helper.
package mmio_led_pwm_pkg;

  // Word offsets (byte offset >> 2) inside the 256-byte window
  localparam logic [5:0] OFS_OUT   = 6'h00;
  localparam logic [5:0] OFS_SET   = 6'h01;
  localparam logic [5:0] OFS_CLR   = 6'h02;
  localparam logic [5:0] OFS_TOG   = 6'h03;
  localparam logic [5:0] OFS_MODE  = 6'h04;
  localparam logic [5:0] OFS_CNT   = 6'h05;
  localparam logic [5:0] OFS_DUTY0 = 6'h10;

  // Replace only the enabled byte lanes of old_v with new_v
  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mmio_led_pwm_timebase.sv
// mmio_led_pwm timebase
// Prescaler plus free-running PWM counter.
module pwm_timebase #(
  parameter int PRESCALE = 64,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic                tick,
  output logic                wrap,
  output logic [PWM_BITS-1:0] cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));
  // wrap marks the tick on which cnt rolls over to 0
  assign wrap = tick && (cnt == '1);

  // prescaler and PWM step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + PW'(1);
      if (tick) cnt <= cnt + PWM_BITS'(1);
    end
  end

endmodule

// File: rtl/mmio_led_pwm.sv
// mmio_led_pwm top
// Memory-mapped static/PWM LED outputs on the data bus.
module mmio_led_pwm
  import mmio_led_pwm_pkg::*;
#(
  parameter int          N_CH      = 8,
  parameter int          PWM_BITS  = 8,
  parameter int          PRESCALE  = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic [31:0]     write_data,
  input  logic            memwrite,
  input  logic            memread,
  input  logic [3:0]      sign_mask,
  output logic [31:0]     read_data,
  output logic [N_CH-1:0] led
);

  logic                sel;
  logic                wr;
  logic [5:0]          ofs;
  logic [5:0]          duty_idx;
  logic                duty_hit;
  logic                tick;
  logic                wrap;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [N_CH-1:0]     out_r, out_nx;
  logic [N_CH-1:0]     mode_r, mode_nx;
  logic [N_CH-1:0]     led_nx;
  logic [N_CH-1:0]     duty_we;
  logic [PWM_BITS-1:0] duty_pend [N_CH];
  logic [PWM_BITS-1:0] duty_act  [N_CH];
  logic [PWM_BITS-1:0] duty_rd;
  logic [PWM_BITS-1:0] duty_nx;
  logic [31:0]         rd_val;

  assign sel      = (addr[31:8] == BASE_ADDR[31:8]);
  assign ofs      = addr[7:2];
  assign wr       = memwrite && sel;
  assign duty_idx = ofs - OFS_DUTY0;
  assign duty_hit = (ofs >= OFS_DUTY0) && (int'(duty_idx) < N_CH);

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_tb (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .wrap  (wrap),
    .cnt   (pwm_cnt)
  );

  // pending duty of the addressed channel and its merged store value
  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < N_CH; i++)
      if (duty_idx == 6'(i)) duty_rd = duty_pend[i];
    duty_nx = PWM_BITS'(lane_merge(32'(duty_rd), write_data, sign_mask));
  end

  // next OUT/MODE values from stores
  always_comb begin
    out_nx  = out_r;
    mode_nx = mode_r;
    if (wr) begin
      case (ofs)
        OFS_OUT:  out_nx  = N_CH'(lane_merge(32'(out_r), write_data, sign_mask));
        OFS_SET:  out_nx  = out_r | N_CH'(write_data);
        OFS_CLR:  out_nx  = out_r & ~N_CH'(write_data);
        OFS_TOG:  out_nx  = out_r ^ N_CH'(write_data);
        OFS_MODE: mode_nx = N_CH'(lane_merge(32'(mode_r), write_data, sign_mask));
        default: ;
      endcase
    end
  end

  // read mux on pre-write state
  always_comb begin
    rd_val = '0;
    if (duty_hit) begin
      rd_val = 32'(duty_rd);
    end else begin
      case (ofs)
        OFS_OUT:  rd_val = 32'(out_r);
        OFS_MODE: rd_val = 32'(mode_r);
        OFS_CNT:  rd_val = 32'(pwm_cnt);
        default:  rd_val = '0;
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign duty_we[g] = wr && duty_hit && (duty_idx == 6'(g));
    assign led_nx[g]  = mode_r[g] ? (pwm_cnt < duty_act[g]) : out_r[g];
  end

  // register state; active duty reloads only at period wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r     <= '0;
      mode_r    <= '0;
      led       <= '0;
      read_data <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_pend[i] <= '0;
        duty_act[i]  <= '0;
      end
    end else begin
      out_r     <= out_nx;
      mode_r    <= mode_nx;
      led       <= led_nx;
      read_data <= (memread && sel) ? rd_val : '0;
      for (int i = 0; i < N_CH; i++) begin
        if (duty_we[i]) duty_pend[i] <= duty_nx;
        if (wrap)       duty_act[i]  <= duty_pend[i];
      end
    end
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb_mmio_led_pwm
// Directed self-checking bench for mmio_led_pwm.
module tb_mmio_led_pwm;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic [7:0]  led;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmio_led_pwm #(
    .N_CH      (8),
    .PWM_BITS  (8),
    .PRESCALE  (2),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .led        (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m);
    @(negedge clk);
    addr = a; write_data = d; sign_mask = m; memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; memread = 1'b1;
    @(negedge clk);
    memread = 1'b0;
    d = read_data;
  endtask

  logic [31:0] rd;
  int          hi;
  int          found;
  logic        prev;

  initial begin
    reset = 1'b1; addr = '0; write_data = '0;
    memwrite = 1'b0; memread = 1'b0; sign_mask = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_led", {24'd0, led}, 32'h0);
    chk("reset_rdata", read_data, 32'h0);

    // static OUT and latency
    bus_wr(BASE + 32'h00, 32'h0000_00A5, 4'b1111);
    chk("led_1cyc", {24'd0, led}, 32'h0);
    @(negedge clk);
    chk("led_2cyc", {24'd0, led}, 32'hA5);
    bus_rd(BASE + 32'h00, rd);
    chk("rd_out", rd, 32'hA5);

    // SET / CLR / TOG
    bus_wr(BASE + 32'h04, 32'h0F, 4'b0000);
    bus_rd(BASE + 32'h00, rd);
    chk("set", rd, 32'hAF);
    bus_wr(BASE + 32'h08, 32'h81, 4'b0000);
    bus_rd(BASE + 32'h00, rd);
    chk("clr", rd, 32'h2E);
    bus_wr(BASE + 32'h0C, 32'hFF, 4'b0001);
    bus_rd(BASE + 32'h00, rd);
    chk("tog", rd, 32'hD1);

    // byte lanes
    bus_wr(BASE + 32'h00, 32'hFFFF_FF33, 4'b0001);
    bus_rd(BASE + 32'h00, rd);
    chk("lane_0001", rd, 32'h33);
    bus_wr(BASE + 32'h00, 32'h0000_0055, 4'b0000);
    bus_rd(BASE + 32'h00, rd);
    chk("lane_0000", rd, 32'h33);

    // window decode and unmapped offsets
    bus_rd(BASE + 32'h100, rd);
    chk("rd_outside", rd, 32'h0);
    bus_rd(BASE + 32'h24, rd);
    chk("rd_unmapped", rd, 32'h0);
    bus_rd(BASE + 32'h04, rd);
    chk("rd_wo_set", rd, 32'h0);
    bus_wr(BASE + 32'h100, 32'h0, 4'b1111);
    bus_rd(BASE + 32'h00, rd);
    chk("wr_outside", rd, 32'h33);

    // PWM on channel 0
    bus_wr(BASE + 32'h08, 32'hFF, 4'b1111);
    bus_wr(BASE + 32'h40, 32'd64, 4'b1111);
    bus_wr(BASE + 32'h10, 32'h01, 4'b1111);
    bus_rd(BASE + 32'h10, rd);
    chk("rd_mode", rd, 32'h01);
    bus_rd(BASE + 32'h40, rd);
    chk("rd_duty", rd, 32'd64);

    found = 0;
    prev = led[0];
    for (int k = 0; k < 1200 && found == 0; k++) begin
      @(negedge clk);
      if (led[0] && !prev) found = 1;
      prev = led[0];
    end
    chk("pwm_start_seen", found, 1);

    hi = 0;
    for (int k = 0; k < 512; k++) begin
      if (k > 0) @(negedge clk);
      if (led[0]) hi++;
      if (k == 200) begin
        addr = BASE + 32'h40; write_data = 32'd192;
        sign_mask = 4'b1111; memwrite = 1'b1;
      end else begin
        memwrite = 1'b0;
      end
    end
    chk("pwm_duty64", hi, 128);

    hi = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    chk("pwm_duty192", hi, 384);
    chk("led_static_off", {24'd0, led[7:1]}, 32'h0);

    bus_rd(BASE + 32'h40, rd);
    chk("rd_duty_pend", rd, 32'd192);

    // reset mid-period with concurrent store and load
    bus_wr(BASE + 32'h00, 32'hFE, 4'b1111);
    repeat (37) @(negedge clk);
    reset = 1'b1; addr = BASE; write_data = 32'hAA;
    sign_mask = 4'b1111; memwrite = 1'b1; memread = 1'b1;
    @(negedge clk);
    reset = 1'b0; memwrite = 1'b0; memread = 1'b0;
    chk("rst_led", {24'd0, led}, 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    bus_rd(BASE + 32'h14, rd);
    chk("rst_cnt", rd, 32'h0);
    bus_rd(BASE + 32'h00, rd);
    chk("rst_out", rd, 32'h0);
    bus_rd(BASE + 32'h10, rd);
    chk("rst_mode", rd, 32'h0);
    bus_rd(BASE + 32'h40, rd);
    chk("rst_duty", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
